instruction_control_unit: RTL and testbench
===========================================

Name: instruction_control_unit

Overview:
- Fetch/decode/execute controller that sits directly upstream of the accumulator/RAM datapath and drives its control inputs (Asel, Aload, Sub, MemWr, RAMAddress).
- Holds the program counter (PC) and the instruction register (IR).
- Consumes the datapath status flags Aeq0 and Apos, and the RAM read data as the instruction word.
- Single-cycle-per-state Moore/Mealy FSM; each instruction takes 3 clocks, except INPUT, which waits for Enter, and HALT.

Parameters:
- ADDR_W, 5, RAM address width; instruction word is 3+ADDR_W bits (opcode in the top 3 bits).
- RESET_PC, 0, PC value loaded on reset and in START.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instr  in  3+ADDR_W  RAM read data; combinational read of the word at RAMAddress.
- Aeq0  in  1  datapath flag: A == 0.
- Apos  in  1  datapath flag: A > 0 (signed).
- Enter  in  1  operator confirms input_data is valid (level, sampled only in INPUT).
- Asel  out  2  A source select: 00 = ALU result, 01 = input_data, 10 = RAM data, 11 unused.
- Aload  out  1  load accumulator.
- Sub  out  1  ALU op: 0 = add, 1 = subtract.
- MemWr  out  1  write A to RAM[RAMAddress].
- RAMAddress  out  ADDR_W  RAM address.
- PC  out  ADDR_W  current program counter (debug).
- Halt  out  1  high in HALT state.

Behaviour:
- Reset (Reset=0, asynchronous, at any time including mid-instruction):
  - state = START, PC = RESET_PC, IR = 0.
  - All outputs 0, except PC = RESET_PC.
  - MemWr never pulses during or on release of reset.
- Opcodes, IR[7:5] for ADDR_W=5:
  - 000 LOAD: A <= RAM[a]
  - 001 STORE: RAM[a] <= A
  - 010 ADD: A <= A + RAM[a]
  - 011 SUB: A <= A - RAM[a]
  - 100 INPUT: A <= input_data
  - 101 JZ: if A == 0, PC <= a
  - 110 JPOS: if A > 0, PC <= a
  - 111 HALT
  - The operand address a is IR[ADDR_W-1:0].
- States: START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT.
- START: one cycle, outputs 0, go to FETCH.
- FETCH:
  - RAMAddress = PC.
  - On the clock edge: IR <= Instr, PC <= PC + 1 (modulo 2^ADDR_W; 31 wraps to 0).
  - Next state is DECODE.
- DECODE:
  - RAMAddress = IR address field, so the operand is on the RAM output.
  - Next state is the opcode's execute state; no datapath strobes.
- Execute states, one cycle each, then FETCH. RAMAddress = IR address field throughout.
  - LOAD: Asel = 10, Aload = 1.
  - STORE: MemWr = 1 for exactly one cycle.
  - ADD: Asel = 00, Sub = 0, Aload = 1.
  - SUB: Asel = 00, Sub = 1, Aload = 1.
  - JZ: if Aeq0 = 1 at the edge, PC <= address; otherwise PC is unchanged.
  - JPOS: same rule as JZ, using Apos.
- INPUT:
  - Asel = 01.
  - Remains in INPUT while Enter = 0, with Aload = 0.
  - In the cycle Enter = 1: Aload = 1 (Mealy), next state FETCH.
- HALT: Halt = 1, all strobes 0, stays in HALT until reset.
- Enter is ignored in every state except INPUT.
- Aeq0 and Apos are ignored outside JZ and JPOS.
- Exactly one of {Aload, MemWr} may be high in any cycle; both low in START, FETCH, DECODE, JZ, JPOS and HALT.
- Latency:
  - LOAD, STORE, ADD, SUB and JZ/JPOS complete 3 clocks after entering FETCH.
  - The first FETCH occurs on the 2nd rising edge after Reset deasserts.

Test Plan:
- Reset mid-STORE: RAM[0] = 8'b001_00101 (STORE 5); assert Reset=0 while in STORE state → MemWr drops to 0 immediately, PC = 0, Halt = 0; the next FETCH after release reads address 0.
- LOAD/ADD/STORE program: RAM[0..3] = LOAD 10, ADD 11, STORE 12, HALT; RAM[10] = 3, RAM[11] = 4 → RAM[12] = 7. Aload is high exactly twice, MemWr exactly once (RAMAddress = 12). Halt rises at cycle 1 + 3×3 + 2, and PC = 4 while halted.
- SUB and JZ taken: A = 5, SUB of RAM[x] = 5 gives Aeq0 = 1; JZ 20 → PC = 20 after the JZ state. Repeat with A = 1 → PC = next sequential address.
- JPOS with negative A: A = 8'hFB, Apos = 0 → no jump; A = 8'h02 → jump to target.
- INPUT handshake: INPUT with Enter held 0 for 4 cycles → state stays INPUT, Asel = 01, Aload = 0. Enter = 1 for one cycle → Aload = 1 in that cycle, then FETCH. Enter pulses during FETCH/DECODE → no effect.
- PC wrap: execute a non-jump at address 31 → next FETCH at address 0.

Source files
------------

// File: rtl/instruction_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator/RAM datapath.
// Owns PC and IR and drives the datapath control strobes from the FSM state.
module instruction_control_unit #(
   parameter int                ADDR_W   = 5,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [ADDR_W+2:0] Instr,
   input  logic              Aeq0,
   input  logic              Apos,
   input  logic              Enter,
   output logic [1:0]        Asel,
   output logic              Aload,
   output logic              Sub,
   output logic              MemWr,
   output logic [ADDR_W-1:0] RAMAddress,
   output logic [ADDR_W-1:0] PC,
   output logic              Halt
);

   localparam int IW = ADDR_W + 3;

   localparam logic [1:0] ASEL_ALU = 2'b00;
   localparam logic [1:0] ASEL_IN  = 2'b01;
   localparam logic [1:0] ASEL_RAM = 2'b10;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_STORE = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_INPUT = 3'b100,
      OP_JZ    = 3'b101,
      OP_JPOS  = 3'b110,
      OP_HALT  = 3'b111
   } opcode_t;

   typedef enum logic [3:0] {
      S_START,
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_ADD,
      S_SUB,
      S_INPUT,
      S_JZ,
      S_JPOS,
      S_HALT
   } state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     ir, ir_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   opcode_t           opcode;
   logic [ADDR_W-1:0] operand;

   assign opcode  = opcode_t'(ir[IW-1 -: 3]);
   assign operand = ir[ADDR_W-1:0];
   assign PC      = pc;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= S_START;
         pc    <= RESET_PC;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      ir_nxt     = ir;
      Asel       = ASEL_ALU;
      Aload      = 1'b0;
      Sub        = 1'b0;
      MemWr      = 1'b0;
      RAMAddress = '0;
      Halt       = 1'b0;

      case (state)
         S_START: state_nxt = S_FETCH;

         S_FETCH: begin
            RAMAddress = pc;
            ir_nxt     = Instr;
            pc_nxt     = pc + 1'b1;
            state_nxt  = S_DECODE;
         end

         // Present the operand address now so RAM data is ready in the execute cycle.
         S_DECODE: begin
            RAMAddress = operand;
            case (opcode)
               OP_LOAD:  state_nxt = S_LOAD;
               OP_STORE: state_nxt = S_STORE;
               OP_ADD:   state_nxt = S_ADD;
               OP_SUB:   state_nxt = S_SUB;
               OP_INPUT: state_nxt = S_INPUT;
               OP_JZ:    state_nxt = S_JZ;
               OP_JPOS:  state_nxt = S_JPOS;
               default:  state_nxt = S_HALT;
            endcase
         end

         S_LOAD: begin
            RAMAddress = operand;
            Asel       = ASEL_RAM;
            Aload      = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_STORE: begin
            RAMAddress = operand;
            MemWr      = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_ADD: begin
            RAMAddress = operand;
            Asel       = ASEL_ALU;
            Aload      = 1'b1;
            state_nxt  = S_FETCH;
         end

         S_SUB: begin
            RAMAddress = operand;
            Asel       = ASEL_ALU;
            Sub        = 1'b1;
            Aload      = 1'b1;
            state_nxt  = S_FETCH;
         end

         // Aload follows Enter combinationally so the value is captured in the confirm cycle.
         S_INPUT: begin
            RAMAddress = operand;
            Asel       = ASEL_IN;
            Aload      = Enter;
            if (Enter) state_nxt = S_FETCH;
         end

         S_JZ: begin
            RAMAddress = operand;
            if (Aeq0) pc_nxt = operand;
            state_nxt = S_FETCH;
         end

         S_JPOS: begin
            RAMAddress = operand;
            if (Apos) pc_nxt = operand;
            state_nxt = S_FETCH;
         end

         S_HALT: Halt = 1'b1;

         default: state_nxt = S_START;
      endcase
   end

endmodule

// File: tb/tb_instruction_control_unit.sv
// Directed bench: a small RAM/accumulator model closes the loop around the controller.
`timescale 1ns/1ps
module tb_instruction_control_unit;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Enter = 1'b0;
   logic       Aeq0, Apos;
   logic [7:0] Instr;
   logic [1:0] Asel;
   logic       Aload, Sub, MemWr, Halt;
   logic [4:0] RAMAddress, PC;

   logic [7:0] ram [32];
   logic [7:0] acc;
   logic [7:0] in_data;
   int         n_chk, n_pass, cyc;

   always #5 Clock = ~Clock;

   assign Instr = ram[RAMAddress];
   assign Aeq0  = (acc == 8'd0);
   assign Apos  = !acc[7] && (acc != 8'd0);

   instruction_control_unit #(.ADDR_W(5), .RESET_PC(5'd0)) dut (
      .Clock(Clock), .Reset(Reset), .Instr(Instr), .Aeq0(Aeq0), .Apos(Apos),
      .Enter(Enter), .Asel(Asel), .Aload(Aload), .Sub(Sub), .MemWr(MemWr),
      .RAMAddress(RAMAddress), .PC(PC), .Halt(Halt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: sample strobes, let the edge happen, then update the RAM/accumulator model.
   task automatic tick;
      logic       wr, ld, sb;
      logic [1:0] sel;
      logic [4:0] a;
      logic [7:0] d;
      #1;
      wr = MemWr; ld = Aload; sb = Sub; sel = Asel; a = RAMAddress; d = Instr;
      @(posedge Clock);
      #1;
      if (wr) ram[a] = acc;
      if (ld) begin
         case (sel)
            2'b00:   acc = sb ? acc - d : acc + d;
            2'b01:   acc = in_data;
            2'b10:   acc = d;
            default: ;
         endcase
      end
      @(negedge Clock);
      cyc++;
   endtask

   task automatic clear_ram;
      for (int i = 0; i < 32; i++) ram[i] = 8'h00;
   endtask

   task automatic do_reset;
      Reset = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      cyc = 0;
   endtask

   initial begin
      int nl, nw, hcyc;
      logic [4:0] waddr;
      n_chk = 0; n_pass = 0; cyc = 0;
      acc = 8'd0; in_data = 8'd0;
      clear_ram();

      // Reset values
      #2 Reset = 1'b0;
      #1;
      chk("rst_asel", Asel, 2'b00);
      chk("rst_aload", Aload, 0);
      chk("rst_sub", Sub, 0);
      chk("rst_memwr", MemWr, 0);
      chk("rst_addr", RAMAddress, 0);
      chk("rst_pc", PC, 0);
      chk("rst_halt", Halt, 0);

      // LOAD 10, ADD 11, STORE 12, HALT
      clear_ram();
      ram[0] = 8'h0A; ram[1] = 8'h4B; ram[2] = 8'h2C; ram[3] = 8'hE0;
      ram[10] = 8'd3; ram[11] = 8'd4;
      acc = 8'd0;
      do_reset();
      nl = 0; nw = 0; hcyc = 0; waddr = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (Aload) nl++;
         if (MemWr) begin nw++; waddr = RAMAddress; end
         if (Halt && hcyc == 0) hcyc = cyc;
      end
      chk("prog_aload_cnt", nl, 2);
      chk("prog_memwr_cnt", nw, 1);
      chk("prog_wr_addr", waddr, 12);
      chk("prog_halt_cyc", hcyc, 12);
      chk("prog_pc_halt", PC, 4);
      chk("prog_ram12", ram[12], 7);
      chk("prog_halt_hold", Halt, 1);

      // SUB to zero then JZ taken
      clear_ram();
      ram[0] = 8'h10; ram[1] = 8'h70; ram[2] = 8'hB4; ram[16] = 8'd5; ram[17] = 8'd6;
      acc = 8'd0;
      do_reset();
      repeat (10) tick();
      chk("jz_taken_acc", acc, 0);
      chk("jz_taken_pc", PC, 20);
      chk("jz_taken_fetch", RAMAddress, 20);

      // Residual 1: JZ not taken
      ram[0] = 8'h11;
      acc = 8'd0;
      do_reset();
      repeat (10) tick();
      chk("jz_not_acc", acc, 1);
      chk("jz_not_pc", PC, 3);

      // JPOS with negative A then positive A
      clear_ram();
      ram[0] = 8'h11; ram[1] = 8'hD4; ram[17] = 8'hFB;
      acc = 8'd0;
      do_reset();
      repeat (7) tick();
      chk("jpos_neg_pc", PC, 2);
      ram[17] = 8'h02;
      acc = 8'd0;
      do_reset();
      repeat (7) tick();
      chk("jpos_pos_pc", PC, 20);

      // INPUT handshake; Enter outside INPUT is ignored
      clear_ram();
      ram[0] = 8'h80; ram[1] = 8'hE0;
      acc = 8'd0; in_data = 8'h2A;
      do_reset();
      Enter = 1'b1;
      tick();
      #1 chk("in_fetch_aload", Aload, 0);
      tick();
      #1 chk("in_decode_aload", Aload, 0);
      Enter = 1'b0;
      tick();
      chk("in_wait_asel", Asel, 2'b01);
      chk("in_wait_aload", Aload, 0);
      repeat (4) tick();
      chk("in_hold_asel", Asel, 2'b01);
      chk("in_hold_aload", Aload, 0);
      chk("in_hold_pc", PC, 1);
      Enter = 1'b1;
      #1;
      chk("in_enter_aload", Aload, 1);
      chk("in_enter_asel", Asel, 2'b01);
      tick();
      Enter = 1'b0;
      #1;
      chk("in_next_fetch", RAMAddress, 1);
      chk("in_next_aload", Aload, 0);
      chk("in_acc", acc, 8'h2A);
      tick(); tick();
      chk("in_halt", Halt, 1);
      Enter = 1'b1;
      tick();
      #1;
      chk("halt_enter_halt", Halt, 1);
      chk("halt_enter_aload", Aload, 0);
      chk("halt_enter_pc", PC, 2);
      Enter = 1'b0;

      // PC wrap: JZ 31 then LOAD at address 31
      clear_ram();
      ram[0] = 8'hBF; ram[31] = 8'h10; ram[16] = 8'd9;
      acc = 8'd0;
      do_reset();
      repeat (4) tick();
      chk("wrap_at31", RAMAddress, 31);
      repeat (3) tick();
      chk("wrap_fetch0", RAMAddress, 0);
      chk("wrap_pc0", PC, 0);
      chk("wrap_acc", acc, 9);

      // Reset asserted while in STORE
      clear_ram();
      ram[0] = 8'h25;
      acc = 8'h55;
      do_reset();
      repeat (3) tick();
      chk("st_memwr_before", MemWr, 1);
      chk("st_addr_before", RAMAddress, 5);
      #2 Reset = 1'b0;
      #1;
      chk("st_rst_memwr", MemWr, 0);
      chk("st_rst_pc", PC, 0);
      chk("st_rst_halt", Halt, 0);
      @(negedge Clock);
      chk("st_rst_memwr_hold", MemWr, 0);
      Reset = 1'b1;
      #1 chk("st_release_memwr", MemWr, 0);
      tick();
      chk("st_refetch_addr", RAMAddress, 0);
      chk("st_refetch_memwr", MemWr, 0);
      tick();
      chk("st_redecode_addr", RAMAddress, 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
